uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx.sv | 100 ++++++++++
 tb/tb_uart_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and oversampling/stop-tick constants,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int OVERSAMPLE = 16;

    localparam int SB_1   = 16;
    localparam int SB_1P5 = 24;
    localparam int SB_2   = 32;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, then SB_TICK ticks of
// stop level, all timed by the 16x oversampling enable s_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = SB_1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    state_t          state;
    logic [5:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;

    // All outputs are registered with the state so the line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
            tx_busy      <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        state   <= START;
                        s       <= '0;
                        b       <= din;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == 6'(OVERSAMPLE - 1)) begin
                            state <= DATA;
                            s     <= '0;
                            n     <= '0;
                            tx    <= b[0];
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == 6'(OVERSAMPLE - 1)) begin
                            s <= '0;
                            b <= b >> 1;
                            if (n == NW'(DBIT - 1)) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                n  <= n + 1'b1;
                                // b[1] is the bit that lands in b[0] after this shift
                                tx <= b[1];
                            end
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == 6'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            s            <= '0;
                            tx_done_tick <= 1'b1;
                            tx_busy      <= 1'b0;
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8N1 and 7-bit/2-stop) driven by one
// sequence, line checked tick by tick against a frame-level reference model.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       tx_start0, tx_start1;
    logic [7:0] din0;
    logic [6:0] din1;
    logic       done0, busy0, tx0;
    logic       done1, busy1, tx1;

    int checks = 0;
    int errors = 0;
    int tick_period = 4;
    int tick_cnt = 0;

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .SB_TICK(SB_1)) dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start0), .s_tick(s_tick),
        .din(din0), .tx_done_tick(done0), .tx_busy(busy0), .tx(tx0)
    );

    uart_tx #(.DBIT(7), .SB_TICK(SB_2)) dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start1), .s_tick(s_tick),
        .din(din1), .tx_done_tick(done1), .tx_busy(busy1), .tx(tx1)
    );

    function automatic logic get_tx(int cfg);
        return (cfg != 0) ? tx1 : tx0;
    endfunction

    function automatic logic get_busy(int cfg);
        return (cfg != 0) ? busy1 : busy0;
    endfunction

    function automatic logic get_done(int cfg);
        return (cfg != 0) ? done1 : done0;
    endfunction

    function automatic logic get_start(int cfg);
        return (cfg != 0) ? tx_start1 : tx_start0;
    endfunction

    // Expected line level during tick j of a frame: 16 ticks per bit, start
    // bit first, data LSB first, stop level for everything after the data.
    function automatic logic exp_bit(int j, logic [7:0] data, int dbit);
        int k;
        if (j < 16) return 1'b0;
        k = j / 16 - 1;
        if (k < dbit) return data[k];
        return 1'b1;
    endfunction

    task automatic set_start(int cfg, logic v);
        if (cfg != 0) tx_start1 = v;
        else          tx_start0 = v;
    endtask

    task automatic set_din(int cfg, logic [7:0] d);
        if (cfg != 0) din1 = d[6:0];
        else          din0 = d;
    endtask

    // One clock: inputs and samples settle 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        tick_cnt++;
        if (tick_cnt >= tick_period) begin
            s_tick   = 1'b1;
            tick_cnt = 0;
        end else begin
            s_tick = 1'b0;
        end
    endtask

    task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(int cfg, logic [7:0] data, bit hold);
        set_din(cfg, data);
        set_start(cfg, 1'b1);
        step();
        if (!hold) set_start(cfg, 1'b0);
        check_output("accept_tx", {31'd0, get_tx(cfg)}, 32'd0);
        check_output("accept_busy", {31'd0, get_busy(cfg)}, 32'd1);
        check_output("accept_done", {31'd0, get_done(cfg)}, 32'd0);
    endtask

    // Follows one frame from the accepting edge to its done pulse.
    task automatic monitor_frame(int cfg, logic [7:0] data, string tag,
                                 int poke_tick, int abort_tick);
        int dbit, sb, total;
        int tick, cyc, bad, busy_low, early, first_bad;
        bit poked, ticked;
        dbit = (cfg != 0) ? 7 : 8;
        sb   = (cfg != 0) ? SB_2 : SB_1;
        total = 16 + 16 * dbit + sb;
        tick = 0; cyc = 0; bad = 0; busy_low = 0; early = 0;
        first_bad = -1; poked = 1'b0;
        while (tick < total && cyc < 20000) begin
            if (abort_tick >= 0 && tick == abort_tick) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check_output({tag, "_abort_tx"}, {31'd0, get_tx(cfg)}, 32'd1);
                check_output({tag, "_abort_busy"}, {31'd0, get_busy(cfg)}, 32'd0);
                check_output({tag, "_abort_done"}, {31'd0, get_done(cfg)}, 32'd0);
                check_output({tag, "_pre_abort_bits"}, bad, 32'd0);
                return;
            end
            if (poke_tick >= 0 && tick == poke_tick && !poked) begin
                set_start(cfg, 1'b1);
                set_din(cfg, 8'h00);
                poked = 1'b1;
            end else if (poked) begin
                set_start(cfg, 1'b0);
            end
            if (s_tick && get_tx(cfg) !== exp_bit(tick, data, dbit)) begin
                bad++;
                if (first_bad < 0) first_bad = tick;
            end
            if (get_busy(cfg) !== 1'b1) busy_low++;
            if (get_done(cfg) !== 1'b0) early++;
            ticked = s_tick;
            step();
            cyc++;
            if (ticked) tick++;
        end
        check_output({tag, "_timeout"}, {31'd0, cyc < 20000}, 32'd1);
        check_output({tag, "_bits"}, bad, 32'd0);
        if (bad != 0) $display("[TB] %s first wrong bit at tick %0d", tag, first_bad);
        check_output({tag, "_busy_in_frame"}, busy_low, 32'd0);
        check_output({tag, "_done_early"}, early, 32'd0);
        check_output({tag, "_done_pulse"}, {31'd0, get_done(cfg)}, 32'd1);
        check_output({tag, "_busy_end"}, {31'd0, get_busy(cfg)}, 32'd0);
        check_output({tag, "_tx_end"}, {31'd0, get_tx(cfg)}, 32'd1);
        if (get_start(cfg) !== 1'b1) begin
            step();
            check_output({tag, "_done_once"}, {31'd0, get_done(cfg)}, 32'd0);
            check_output({tag, "_idle_tx"}, {31'd0, get_tx(cfg)}, 32'd1);
        end
    endtask

    initial begin
        int ticks, bad;
        logic [7:0] rdata;
        int rcfg;

        reset = 1'b1; s_tick = 1'b0;
        tx_start0 = 1'b0; tx_start1 = 1'b0; din0 = '0; din1 = '0;
        $display("[TB] start");

        step();
        step();
        reset = 1'b0;
        check_output("reset_tx", {31'd0, tx0}, 32'd1);
        check_output("reset_busy", {31'd0, busy0}, 32'd0);
        check_output("reset_done", {31'd0, done0}, 32'd0);
        check_output("reset_tx_7b", {31'd0, tx1}, 32'd1);

        ticks = 0; bad = 0;
        while (ticks < 200) begin
            if ({tx0, busy0, done0, tx1, busy1, done1} !== 6'b100100) bad++;
            if (s_tick) ticks++;
            step();
        end
        check_output("idle_200_ticks", bad, 32'd0);

        tick_period = 4;
        apply_stimulus(0, 8'hA5, 1'b0);
        monitor_frame(0, 8'hA5, "single_a5", -1, -1);

        apply_stimulus(0, 8'hA5, 1'b0);
        monitor_frame(0, 8'hA5, "ignored_req", 16 * 3 + 5, -1);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
            step();
        end
        check_output("no_second_frame", bad, 32'd0);

        apply_stimulus(0, 8'h0F, 1'b1);
        set_din(0, 8'hF0);
        monitor_frame(0, 8'h0F, "b2b_first", -1, -1);
        apply_stimulus(0, 8'hF0, 1'b0);
        monitor_frame(0, 8'hF0, "b2b_second", -1, -1);

        apply_stimulus(1, 8'h55, 1'b0);
        monitor_frame(1, 8'h55, "two_stop_7b", -1, -1);

        apply_stimulus(0, 8'h3C, 1'b0);
        monitor_frame(0, 8'h3C, "reset_mid", -1, 16 + 16 * 3 + 6);
        apply_stimulus(0, 8'h96, 1'b0);
        monitor_frame(0, 8'h96, "after_reset", -1, -1);

        for (int i = 0; i < 4; i++) begin
            tick_period = $urandom_range(1, 6);
            rcfg  = $urandom_range(0, 1);
            rdata = 8'($urandom);
            if (rcfg != 0) rdata[7] = 1'b0;
            $display("[TB] random frame cfg=%0d data=%02h period=%0d", rcfg, rdata, tick_period);
            apply_stimulus(rcfg, rdata, 1'b0);
            monitor_frame(rcfg, rdata, "random", -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
